// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the write-back entry format.
package cpu_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int NUM_REGISTERS = 32;
    localparam int REG_IDX_WIDTH = $clog2(NUM_REGISTERS);

    typedef struct packed {
        logic [REG_IDX_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of DEPTH write-back entries. It exposes the whole storage
// array with per-slot valid bits and the read pointer, so the parent can
// build the pending bitmap and search for forwarded values by age.
module wb_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  wb_entry_t                        push_entry,
    input  logic                             pop,
    output wb_entry_t                        head,
    output logic                             full,
    output logic                             empty,
    output wb_entry_t [DEPTH-1:0]            entries,
    output logic [DEPTH-1:0]                 entry_valid,
    output logic [$clog2(DEPTH)-1:0]         rd_ptr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  do_push;
    logic                  do_pop;

    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign head        = empty ? '0 : mem_q[rd_ptr_q];
    assign entries     = mem_q;
    assign entry_valid = valid_q;
    assign rd_ptr      = rd_ptr_q;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally
    // because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q]   = push_entry;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State register; reset flushes every queued entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/writeback_queue.sv
// Register-file write-back queue: arbitrates load and ALU results into an
// in-order FIFO, drains the head onto the write port, and publishes a
// pending-write bitmap. Optional read forwarding from queued entries is
// built when WB_FORWARD_EN is defined; otherwise the forwarding outputs are 0.
module writeback_queue
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [REG_IDX_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [REG_IDX_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    output logic [REG_IDX_WIDTH-1:0] write_register,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic                     write_data_valid,
    input  logic                     write_valid,
    output logic [NUM_REGISTERS-1:0] pending,
    input  logic [REG_IDX_WIDTH-1:0] query_reg_1,
    input  logic [REG_IDX_WIDTH-1:0] query_reg_2,
    output logic                     fwd_hit_1,
    output logic                     fwd_hit_2,
    output logic [DATA_WIDTH-1:0]    fwd_data_1,
    output logic [DATA_WIDTH-1:0]    fwd_data_2
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t             push_entry;
    wb_entry_t             head;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      entry_valid;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    assign mem_ready = !full && !rst;
    assign alu_ready = !full && !mem_valid && !rst;

    // Load wins arbitration; results aimed at x0 complete the handshake but are dropped.
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (mem_valid && mem_ready) begin
            push       = (mem_rd != '0);
            push_entry = '{rd: mem_rd, data: mem_data};
        end else if (alu_valid && alu_ready) begin
            push       = (alu_rd != '0);
            push_entry = '{rd: alu_rd, data: alu_data};
        end
    end

    assign pop              = !empty && write_valid;
    assign write_data_valid = !empty;
    assign write_register   = head.rd;
    assign write_data       = head.data;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_entry  (push_entry),
        .pop         (pop),
        .head        (head),
        .full        (full),
        .empty       (empty),
        .entries     (entries),
        .entry_valid (entry_valid),
        .rd_ptr      (rd_ptr)
    );

    // Pending bitmap: one bit per register targeted by any live entry.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i]) pending[entries[i].rd] = 1'b1;
        end
        pending[0] = 1'b0;
    end

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] idx;

    // Walk from oldest to youngest so the last match seen is the youngest.
    always_comb begin
        fwd_hit_1  = 1'b0;
        fwd_hit_2  = 1'b0;
        fwd_data_1 = '0;
        fwd_data_2 = '0;
        idx        = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (entry_valid[idx] && query_reg_1 != '0 && entries[idx].rd == query_reg_1) begin
                fwd_hit_1  = 1'b1;
                fwd_data_1 = entries[idx].data;
            end
            if (entry_valid[idx] && query_reg_2 != '0 && entries[idx].rd == query_reg_2) begin
                fwd_hit_2  = 1'b1;
                fwd_data_2 = entries[idx].data;
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{query_reg_1, query_reg_2, rd_ptr};
    assign fwd_hit_1  = 1'b0;
    assign fwd_hit_2  = 1'b0;
    assign fwd_data_1 = '0;
    assign fwd_data_2 = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboarded bench for writeback_queue: directed pushes record the
// expected register-file writes; a negedge monitor checks every commit.
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, alu_valid;
    logic        mem_ready, alu_ready;
    logic [4:0]  mem_rd, alu_rd;
    logic [31:0] mem_data, alu_data;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        write_data_valid;
    logic        write_valid;
    logic [31:0] pending;
    logic [4:0]  query_reg_1, query_reg_2;
    logic        fwd_hit_1, fwd_hit_2;
    logic [31:0] fwd_data_1, fwd_data_2;

    logic        wv_follow;
    logic        wv_manual;

    int n_cmp = 0;
    int n_err = 0;

    logic [36:0] exp_q[$];

    always #5 clk = ~clk;

    assign write_valid = wv_follow ? write_data_valid : wv_manual;

    writeback_queue #(.DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_valid        (mem_valid),
        .mem_ready        (mem_ready),
        .mem_rd           (mem_rd),
        .mem_data         (mem_data),
        .alu_valid        (alu_valid),
        .alu_ready        (alu_ready),
        .alu_rd           (alu_rd),
        .alu_data         (alu_data),
        .write_register   (write_register),
        .write_data       (write_data),
        .write_data_valid (write_data_valid),
        .write_valid      (write_valid),
        .pending          (pending),
        .query_reg_1      (query_reg_1),
        .query_reg_2      (query_reg_2),
        .fwd_hit_1        (fwd_hit_1),
        .fwd_hit_2        (fwd_hit_2),
        .fwd_data_1       (fwd_data_1),
        .fwd_data_2       (fwd_data_2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    // Commit monitor: every register-file write must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && write_data_valid && write_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, write_register}, 32'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("commit_rd",   {27'd0, write_register}, {27'd0, e[36:32]});
                chk("commit_data", write_data, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one result for a single cycle and check it is accepted.
    task automatic do_push(input bit is_mem, input logic [4:0] rd, input logic [31:0] d,
                           input bit track);
        if (is_mem) begin
            mem_valid = 1'b1; mem_rd = rd; mem_data = d;
        end else begin
            alu_valid = 1'b1; alu_rd = rd; alu_data = d;
        end
        @(negedge clk);
        chk(is_mem ? "mem_ready_accept" : "alu_ready_accept",
            {31'd0, is_mem ? mem_ready : alu_ready}, 32'd1);
        if (track && rd != 5'd0) exp_q.push_back({rd, d});
        step();
        if (is_mem) mem_valid = 1'b0; else alu_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        mem_valid = 1'b0; alu_valid = 1'b0;
        mem_rd = '0; alu_rd = '0; mem_data = '0; alu_data = '0;
        query_reg_1 = '0; query_reg_2 = '0;
        wv_follow = 1'b1; wv_manual = 1'b0;

        // Reset state
        step(); step();
        @(negedge clk);
        chk("rst_wdv",       {31'd0, write_data_valid}, 32'd0);
        chk("rst_wreg",      {27'd0, write_register}, 32'd0);
        chk("rst_wdata",     write_data, 32'd0);
        chk("rst_pending",   pending, 32'd0);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst_fwd_hit",   {31'd0, fwd_hit_1}, 32'd0);
        step();
        rst = 1'b0;

        // Single ALU result, pending for one cycle
        do_push(1'b0, 5'd5, 32'hDEADBEEF, 1'b1);
        @(negedge clk);
        chk("single_wdv",     {31'd0, write_data_valid}, 32'd1);
        chk("single_pending", pending, 32'h0000_0020);
        @(negedge clk);
        chk("single_pending_clr", pending, 32'd0);
        chk("single_wdv_clr",     {31'd0, write_data_valid}, 32'd0);
        step();

        // Simultaneous load and ALU: load first, ALU the following cycle
        mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'hAAAA_0003;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hBBBB_0004;
        @(negedge clk);
        chk("arb_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("arb_alu_ready", {31'd0, alu_ready}, 32'd0);
        exp_q.push_back({5'd3, 32'hAAAA_0003});
        step();
        mem_valid = 1'b0;
        @(negedge clk);
        chk("arb_alu_ready_next", {31'd0, alu_ready}, 32'd1);
        exp_q.push_back({5'd4, 32'hBBBB_0004});
        step();
        alu_valid = 1'b0;
        repeat (3) step();

        // Fill with commits stalled, then drain
        wv_follow = 1'b0; wv_manual = 1'b0;
        do_push(1'b0, 5'd8,  32'h0000_0108, 1'b1);
        do_push(1'b1, 5'd9,  32'h0000_0109, 1'b1);
        do_push(1'b0, 5'd10, 32'h0000_010A, 1'b1);
        do_push(1'b1, 5'd11, 32'h0000_010B, 1'b1);
        @(negedge clk);
        chk("full_mem_ready", {31'd0, mem_ready}, 32'd0);
        chk("full_alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("full_pending",   pending, 32'h0000_0F00);
        step();
        wv_manual = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_wdv", {31'd0, write_data_valid}, 32'd1);
            chk(i == 0 ? "full_pop_ready" : "ready_after_pop", {31'd0, mem_ready},
                (i == 0) ? 32'd0 : 32'd1);
        end
        @(negedge clk);
        chk("drain_empty", {31'd0, write_data_valid}, 32'd0);
        step();
        wv_manual = 1'b0; wv_follow = 1'b1;

        // rd = 0 is accepted and discarded
        do_push(1'b0, 5'd0, 32'h0000_1234, 1'b1);
        @(negedge clk);
        chk("x0_wdv",     {31'd0, write_data_valid}, 32'd0);
        chk("x0_pending", pending, 32'd0);
        step();

        // Two writes to r7: youngest forwarded, pending until both drain
        wv_follow = 1'b0; wv_manual = 1'b0;
        query_reg_1 = 5'd7; query_reg_2 = 5'd0;
        do_push(1'b0, 5'd7, 32'h0000_0011, 1'b1);
        do_push(1'b1, 5'd7, 32'h0000_0022, 1'b1);
        @(negedge clk);
        chk("dup_pending", pending, 32'h0000_0080);
`ifdef WB_FORWARD_EN
        chk("fwd_hit_1",  {31'd0, fwd_hit_1}, 32'd1);
        chk("fwd_data_1", fwd_data_1, 32'h0000_0022);
        chk("fwd_hit_2_zero_query", {31'd0, fwd_hit_2}, 32'd0);
`else
        chk("fwd_hit_1_off",  {31'd0, fwd_hit_1}, 32'd0);
        chk("fwd_data_1_off", fwd_data_1, 32'd0);
`endif
        step();
        wv_manual = 1'b1;
        step();
        wv_manual = 1'b0;
        @(negedge clk);
        chk("dup_pending_after_1", pending, 32'h0000_0080);
`ifdef WB_FORWARD_EN
        chk("fwd_data_after_1", fwd_data_1, 32'h0000_0022);
`endif
        step();
        wv_manual = 1'b1;
        step();
        wv_manual = 1'b0;
        @(negedge clk);
        chk("dup_pending_after_2", pending, 32'd0);
        step();

        // Reset with three entries queued flushes them
        do_push(1'b0, 5'd12, 32'h0000_000C, 1'b0);
        do_push(1'b0, 5'd13, 32'h0000_000D, 1'b0);
        do_push(1'b0, 5'd14, 32'h0000_000E, 1'b0);
        @(negedge clk);
        chk("pre_rst_pending", pending, 32'h0000_7000);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("in_rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        chk("in_rst_alu_ready", {31'd0, alu_ready}, 32'd0);
        step();
        @(negedge clk);
        chk("flush_wdv",     {31'd0, write_data_valid}, 32'd0);
        chk("flush_pending", pending, 32'd0);
        chk("flush_wreg",    {27'd0, write_register}, 32'd0);
        step();
        rst = 1'b0;
        wv_follow = 1'b1;
        @(negedge clk);
        chk("post_rst_mem_ready", {31'd0, mem_ready}, 32'd1);
        chk("post_rst_alu_ready", {31'd0, alu_ready}, 32'd1);
        chk("post_rst_wdv",       {31'd0, write_data_valid}, 32'd0);
        repeat (3) step();

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_queue.md
# writeback_queue

Writer-side front end for the architectural register file. Accepts completed results from the ALU and the load unit over valid/ready handshakes, buffers them in order in a small FIFO, and drains one entry per cycle onto the register file write port (`write_register`/`write_data`/`write_data_valid`, completion on `write_valid`). It also exports a per-register pending bitmap so decode can stall on outstanding writes, plus optional read forwarding from queued entries.

## Interface
- `DEPTH`, 4: queue entries; power of two, at least 2.
- `clk`  in  1  clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_valid`  in  1  load result offered.
- `mem_ready`  out  1  load result accepted this cycle.
- `mem_rd`  in  5  destination register index.
- `mem_data`  in  32  load data.
- `alu_valid`  in  1  ALU result offered.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `alu_rd`  in  5  destination register index.
- `alu_data`  in  32  ALU data.
- `write_register`  out  5  head entry index to register file.
- `write_data`  out  32  head entry data.
- `write_data_valid`  out  1  head entry present.
- `write_valid`  in  1  register file commits head on next posedge.
- `pending`  out  32  bit i set while any queued entry targets register i.
- `query_reg_1`, `query_reg_2`  in  5 each  forwarding lookup indices.
- `fwd_hit_1`, `fwd_hit_2`  out  1 each  queued value exists for query.
- `fwd_data_1`, `fwd_data_2`  out  32 each  youngest matching queued data.

## Operation
- Enqueue: at most one entry per cycle. Load has fixed priority over ALU.
  - `mem_ready = !full && !rst`.
  - `alu_ready = !full && !mem_valid && !rst`.
  - A handshake (`valid && ready`) with rd == 0 is accepted and discarded: no entry, no pending bit.
- Drain: `write_data_valid = !empty`. `write_register`/`write_data` come from the head entry and are zero when empty. The head pops on the posedge where `write_data_valid && write_valid`.
- Full queue: ready stays low even if a pop occurs in the same cycle; there is no pass-through. Empty queue: nothing is presented; there is no bypass from input to write port.
- Simultaneous push and pop in a non-full, non-empty queue: count is unchanged and pointers both advance.
- Pointers wrap modulo DEPTH. Count runs 0..DEPTH.
- `pending` is combinational over valid entries. A register with two queued writes stays pending until both drain. Bit 0 is always 0.
- Forwarding: hit when a valid entry's rd equals the query index and the query is nonzero. With multiple matches, data is taken from the youngest entry. Entries are not popped by forwarding.

## Timing
- Accepted result appears at the write port, and in `pending`/forwarding, the cycle after acceptance at the earliest. Minimum latency from handshake to register-file commit is 2 posedges.
- Throughput is 1 write per cycle sustained.
- `pending` bit clears the cycle after the last matching entry pops.
- Reset values:
  - count = 0, pointers = 0.
  - `write_data_valid` = 0, `write_register` = 0, `write_data` = 0.
  - `pending` = 0.
  - `mem_ready` = 0, `alu_ready` = 0.
  - `fwd_hit_*` = 0.
- Reset asserted mid-operation flushes all queued entries on that posedge. Writes still in flight are lost by design.

## Configuration
- `WB_FORWARD_EN` defined: forwarding lookup logic is present as described in Operation.
- Undefined: `fwd_hit_*` are tied to 0 and `fwd_data_*` to 0. Query inputs are ignored. Ports remain present.

## Structure
- Shared package `cpu_pkg` holds:
  - `DATA_WIDTH` = 32.
  - `NUM_REGISTERS` = 32.
  - `REG_IDX_WIDTH` = $clog2(NUM_REGISTERS).
  - typedef `wb_entry_t` packed struct {rd, data}.
- One sub-module, `wb_fifo`: generic DEPTH x `wb_entry_t` circular buffer exposing push/pop/full/empty/head and its valid-entry array for `pending` and forwarding.

## Test plan
- Reset, then single ALU result rd=5 data=0xDEADBEEF with `write_valid` tied to `write_data_valid`:
  - `write_data_valid` rises the next cycle with rd=5 and the data.
  - `pending[5]` is high for exactly 1 cycle.
- `mem_valid` and `alu_valid` both high, same cycle:
  - `mem_ready`=1, `alu_ready`=0.
  - Load entry drains before the ALU entry, which is accepted the following cycle.
- Hold `write_valid`=0 and push 4 entries:
  - `mem_ready`/`alu_ready` go 0.
  - Release `write_valid`: entries drain in FIFO order, 1 per cycle.
  - Ready returns the cycle after the first pop.
- Push rd=0 data=0x1234:
  - Accepted (ready=1).
  - `write_data_valid` stays 0 and `pending` stays 0.
- Queue rd=7 with 0x11, then rd=7 with 0x22, with `WB_FORWARD_EN` and `query_reg_1`=7:
  - `fwd_hit_1`=1, `fwd_data_1`=0x22.
  - `pending[7]` holds until the second pop.
- Assert `rst` with 3 entries queued:
  - Next cycle count=0, `write_data_valid`=0, `pending`=0, readies 0.
  - After deassert, readies = 1.
